ex_mem_stage_reg: RTL and testbench

Parametrised EX/MEM pipeline stage register for the pipelined CPU. It sits between the ALU/forwarding stage and the data-memory stage, and captures the EX results and MEM/WB control bits. Beyond a plain per-cycle latch, it supports pipeline stall (hold), flush (bubble insertion), a per-stage valid bit and x0 write suppression. It also provides combinational forwarding qualifiers for the hazard unit.

---
 rtl/cpu_pipe_pkg.sv | 23 ++
 rtl/pipe_hold_reg.sv | 36 +++
 rtl/ex_mem_stage_reg.sv | 117 +++++++++++
 tb/tb_ex_mem_stage_reg.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types and defaults for the CPU pipeline registers.
// Holds register widths, memory access size encodings and the EX/MEM control bundle.
package cpu_pipe_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_RADDR_W = 5;
    localparam int DEF_MSIZE_W = 3;

    // Load/store size and sign, funct3 encoding.
    localparam logic [2:0] MSZ_B  = 3'b000;
    localparam logic [2:0] MSZ_H  = 3'b001;
    localparam logic [2:0] MSZ_W  = 3'b010;
    localparam logic [2:0] MSZ_BU = 3'b100;
    localparam logic [2:0] MSZ_HU = 3'b101;

    typedef struct packed {
        logic regWrite;
        logic memToReg;
        logic memRead;
        logic memWrite;
    } exmem_ctrl_t;

endpackage

// File: rtl/pipe_hold_reg.sv
// Generic pipeline register with synchronous reset, clear-to-zero and hold.
// Priority on each edge: reset, then clear, then load when enabled.
module pipe_hold_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with stall, flush, valid tracking, x0 write suppression and forwarding qualifiers.
// Optional stall-cycle counter on stall_cnt_o is built when EXMEM_PERF_CNT_EN is defined.
module ex_mem_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int MSIZE_W = DEF_MSIZE_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic               RegWrite_i,
    input  logic               MemtoReg_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic [MSIZE_W-1:0] MemSize_i,
    input  logic [XLEN-1:0]    ALUResult_i,
    input  logic [XLEN-1:0]    RS2data_i,
    input  logic [RADDR_W-1:0] RDaddr_i,
    output logic               valid_o,
    output logic               RegWrite_o,
    output logic               MemtoReg_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic [MSIZE_W-1:0] MemSize_o,
    output logic [XLEN-1:0]    ALUResult_o,
    output logic [XLEN-1:0]    RS2data_o,
    output logic [RADDR_W-1:0] RDaddr_o,
    output logic               fwd_alu_o,
    output logic               load_use_o
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);

    localparam int CTRL_W = 1 + $bits(exmem_ctrl_t);
    localparam int DATA_W = MSIZE_W + 2 * XLEN + RADDR_W;

    exmem_ctrl_t       ctrl_in;
    exmem_ctrl_t       ctrl_out;
    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic              data_en;

    // Controls of a non-valid slot collapse to a bubble; writes to x0 die here.
    always_comb begin
        ctrl_in.regWrite = RegWrite_i & valid_i & (RDaddr_i != '0);
        ctrl_in.memToReg = MemtoReg_i & valid_i;
        ctrl_in.memRead  = MemRead_i & valid_i;
        ctrl_in.memWrite = MemWrite_i & valid_i;
    end

    assign ctrl_d  = {valid_i, ctrl_in};
    assign data_d  = {MemSize_i, ALUResult_i, RS2data_i, RDaddr_i};
    assign data_en = ~stall_i & ~flush_i;

    pipe_hold_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (~stall_i),
        .clr_i (flush_i),
        .d_i   (ctrl_d),
        .q_o   (ctrl_q)
    );

    // Data fields are don't-care in a bubble, so a flush simply holds them.
    pipe_hold_reg #(.WIDTH(DATA_W)) u_data_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (data_en),
        .clr_i (1'b0),
        .d_i   (data_d),
        .q_o   (data_q)
    );

    assign ctrl_out   = ctrl_q[CTRL_W-2:0];
    assign valid_o    = ctrl_q[CTRL_W-1];
    assign RegWrite_o = ctrl_out.regWrite;
    assign MemtoReg_o = ctrl_out.memToReg;
    assign MemRead_o  = ctrl_out.memRead;
    assign MemWrite_o = ctrl_out.memWrite;

    assign {MemSize_o, ALUResult_o, RS2data_o, RDaddr_o} = data_q;

    assign fwd_alu_o  = valid_o & RegWrite_o & ~MemtoReg_o;
    assign load_use_o = valid_o & MemRead_o;

`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;

    // Counts edges that hold a real instruction; saturates instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_i && !flush_i && valid_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed self-checking bench for ex_mem_stage_reg with hand-computed expectations.
// Counter checks are compiled in only when EXMEM_PERF_CNT_EN is defined.
module tb_ex_mem_stage_reg;
    import cpu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        validIn;
    logic        regWriteIn;
    logic        memToRegIn;
    logic        memReadIn;
    logic        memWriteIn;
    logic [2:0]  memSizeIn;
    logic [31:0] aluIn;
    logic [31:0] rs2In;
    logic [4:0]  rdIn;

    logic        validOut;
    logic        regWriteOut;
    logic        memToRegOut;
    logic        memReadOut;
    logic        memWriteOut;
    logic [2:0]  memSizeOut;
    logic [31:0] aluOut;
    logic [31:0] rs2Out;
    logic [4:0]  rdOut;
    logic        fwdAlu;
    logic        loadUse;
`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] stallCnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage_reg dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .flush_i     (flush),
        .valid_i     (validIn),
        .RegWrite_i  (regWriteIn),
        .MemtoReg_i  (memToRegIn),
        .MemRead_i   (memReadIn),
        .MemWrite_i  (memWriteIn),
        .MemSize_i   (memSizeIn),
        .ALUResult_i (aluIn),
        .RS2data_i   (rs2In),
        .RDaddr_i    (rdIn),
        .valid_o     (validOut),
        .RegWrite_o  (regWriteOut),
        .MemtoReg_o  (memToRegOut),
        .MemRead_o   (memReadOut),
        .MemWrite_o  (memWriteOut),
        .MemSize_o   (memSizeOut),
        .ALUResult_o (aluOut),
        .RS2data_o   (rs2Out),
        .RDaddr_o    (rdOut),
        .fwd_alu_o   (fwdAlu),
        .load_use_o  (loadUse)
`ifdef EXMEM_PERF_CNT_EN
        ,
        .stall_cnt_o (stallCnt)
`endif
    );

    // Upstream must never present a valid read-and-write instruction.
    always @(posedge clk) begin
        assert (!(validIn && memReadIn && memWriteIn)) else begin
            errors++;
            $error("[TB] FAIL illegal_rw: MemRead_i and MemWrite_i both 1 with valid_i=1");
        end
    end

    task automatic applyStimulus(input logic v, input logic rw, input logic m2r, input logic mr,
                                 input logic mw, input logic [2:0] sz, input logic [31:0] alu,
                                 input logic [31:0] rs2, input logic [4:0] rd);
        validIn    = v;
        regWriteIn = rw;
        memToRegIn = m2r;
        memReadIn  = mr;
        memWriteIn = mw;
        memSizeIn  = sz;
        aluIn      = alu;
        rs2In      = rs2;
        rdIn       = rd;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, MSZ_W, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);

        // Reset for two edges with nonzero inputs present
        for (int i = 0; i < 2; i++) begin
            stepClock();
            checkOutput("rst_valid", validOut, 1'b0);
            checkOutput("rst_regwrite", regWriteOut, 1'b0);
            checkOutput("rst_memread", memReadOut, 1'b0);
            checkOutput("rst_alu", aluOut, 32'h0);
            checkOutput("rst_rs2", rs2Out, 32'h0);
            checkOutput("rst_rd", rdOut, 32'h0);
            checkOutput("rst_size", memSizeOut, 32'h0);
`ifdef EXMEM_PERF_CNT_EN
            checkOutput("rst_cnt", stallCnt, 32'h0);
`endif
        end

        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MSZ_W, 32'h1234_5678, 32'h0, 5'd5);
        stepClock();
        checkOutput("load_valid", validOut, 1'b1);
        checkOutput("load_rd", rdOut, 32'd5);
        checkOutput("load_alu", aluOut, 32'h1234_5678);
        checkOutput("load_fwd", fwdAlu, 1'b1);
        checkOutput("load_loaduse", loadUse, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MSZ_W, 32'hAAAA_0000, 32'h0, 5'd0);
        stepClock();
        checkOutput("x0_regwrite", regWriteOut, 1'b0);
        checkOutput("x0_fwd", fwdAlu, 1'b0);
        checkOutput("x0_valid", validOut, 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, MSZ_W, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7);
        stepClock();
        checkOutput("store_memwrite", memWriteOut, 1'b1);
        checkOutput("store_rs2", rs2Out, 32'hDEAD_BEEF);

        // Stall three edges while the inputs move to a different instruction
        stall = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MSZ_H, 32'h0000_0200, 32'h1111_1111, 5'd9);
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput("stall_rs2", rs2Out, 32'hDEAD_BEEF);
            checkOutput("stall_alu", aluOut, 32'h0000_0100);
            checkOutput("stall_memwrite", memWriteOut, 1'b1);
            checkOutput("stall_regwrite", regWriteOut, 1'b0);
            checkOutput("stall_size", memSizeOut, MSZ_W);
        end
`ifdef EXMEM_PERF_CNT_EN
        checkOutput("stall_cnt3", stallCnt, 32'd3);
`endif
        stall = 1'b0;
        stepClock();
        checkOutput("release_rs2", rs2Out, 32'h1111_1111);
        checkOutput("release_alu", aluOut, 32'h0000_0200);
        checkOutput("release_memwrite", memWriteOut, 1'b0);
        checkOutput("release_rd", rdOut, 32'd9);
        checkOutput("release_fwd", fwdAlu, 1'b1);
        checkOutput("release_size", memSizeOut, MSZ_H);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, MSZ_W, 32'h0000_0300, 32'h0, 5'd3);
        stepClock();
        checkOutput("ld_loaduse", loadUse, 1'b1);
        checkOutput("ld_fwd", fwdAlu, 1'b0);
        checkOutput("ld_memtoreg", memToRegOut, 1'b1);

        // Flush and stall on the same edge: bubble wins, data fields hold
        stall = 1'b1;
        flush = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MSZ_B, 32'h0000_0400, 32'h2222_2222, 5'd8);
        stepClock();
        checkOutput("flush_valid", validOut, 1'b0);
        checkOutput("flush_memread", memReadOut, 1'b0);
        checkOutput("flush_loaduse", loadUse, 1'b0);
        checkOutput("flush_regwrite", regWriteOut, 1'b0);
        checkOutput("flush_memtoreg", memToRegOut, 1'b0);
        checkOutput("flush_alu_hold", aluOut, 32'h0000_0300);
        checkOutput("flush_rd_hold", rdOut, 32'd3);
`ifdef EXMEM_PERF_CNT_EN
        checkOutput("flush_cnt", stallCnt, 32'd3);
`endif

        stall = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, MSZ_HU, 32'h0000_0500, 32'h3333_3333, 5'd4);
        stepClock();
        checkOutput("inv_valid", validOut, 1'b0);
        checkOutput("inv_regwrite", regWriteOut, 1'b0);
        checkOutput("inv_memtoreg", memToRegOut, 1'b0);
        checkOutput("inv_memread", memReadOut, 1'b0);
        checkOutput("inv_memwrite", memWriteOut, 1'b0);
        checkOutput("inv_rd", rdOut, 32'd4);
        checkOutput("inv_size", memSizeOut, MSZ_HU);

        // A stall over a bubble does not count
        stall = 1'b1;
        stepClock();
`ifdef EXMEM_PERF_CNT_EN
        checkOutput("bubble_stall_cnt", stallCnt, 32'd3);
`endif
        checkOutput("bubble_stall_rd", rdOut, 32'd4);

        // Reset asserted mid-stall wins on that edge
        rst = 1'b1;
        stepClock();
        checkOutput("rst_stall_rd", rdOut, 32'd0);
        checkOutput("rst_stall_alu", aluOut, 32'h0);
`ifdef EXMEM_PERF_CNT_EN
        checkOutput("rst_stall_cnt", stallCnt, 32'd0);
`endif
        rst   = 1'b0;
        stall = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MSZ_BU, 32'h0000_0600, 32'h0, 5'd6);
        stepClock();
        checkOutput("post_rst_valid", validOut, 1'b1);
        checkOutput("post_rst_alu", aluOut, 32'h0000_0600);
        checkOutput("post_rst_fwd", fwdAlu, 1'b1);

`ifdef EXMEM_PERF_CNT_EN
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput("sat_cnt", stallCnt, 32'hFFFF_FFFF);
        end
        stall = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
